// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequences one memory access at a time for the control unit: loads the MAR,
// for writes loads the MDR from the bus, then raises the read or write strobe
// until memory acknowledges and finishes with a one-cycle done pulse.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to add an 8-bit wait counter.
// An access that sees no ack for WAIT_MAX strobe cycles is then abandoned
// through ERR with a one-cycle err pulse. Without the macro, READ and WRITE
// wait forever and err is tied low.
//
// Handshake: req is looked at only in IDLE. The access is accepted on the
// rising edge where state is IDLE and req=1, and we is captured on that edge.
// ack is looked at only in READ/WRITE. The strobe stays high until the edge
// where ack=1 is sampled.
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   req       in   access request (sampled in IDLE only)
//   we        in   1 = write, 0 = read (captured with req)
//   ack       in   memory ready/acknowledge
//   mar_en    out  MAR load enable
//   mdr_en    out  MDR load enable
//   mdr_read  out  MDR input select: 1 = memory data, 0 = bus data
//   mem_rd    out  memory read strobe
//   mem_wr    out  memory write strobe
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//   err       out  one-cycle timeout pulse
//   state_dbg out  current FSM state encoding (for observation only)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int WAIT_MAX = 15   // legal range 1..255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       we,
   input  logic       ack,
   output logic       mar_en,
   output logic       mdr_en,
   output logic       mdr_read,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_LDMDR = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   wr_flag;       // we captured at acceptance
   logic   mdr_ld_q;      // registered MDR load for the LDMDR state
   logic   rd_ack;        // memory data arriving this cycle
   logic   wait_expired;  // no ack and the wait budget is used up

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       err_q;

   // WAIT_MAX strobe cycles without ack send the FSM to ERR. An ack in the
   // last allowed cycle still completes the access normally.
   assign wait_expired = (wait_cnt == 8'(WAIT_MAX - 1)) && !ack;
   assign err          = err_q;
`else
   assign wait_expired = 1'b0;
   assign err          = 1'b0;
`endif

   // Read data is taken in the same cycle ack arrives, so the MDR enable and
   // select in READ follow ack directly. Reset masks it so an aborted read
   // never loads the MDR on the following negedge.
   assign rd_ack   = (state == S_READ) && ack && !reset;
   assign mdr_en   = mdr_ld_q | rd_ack;
   assign mdr_read = rd_ack;

   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req) state_nxt = S_ADDR;
         S_ADDR:  state_nxt = wr_flag ? S_LDMDR : S_READ;
         S_LDMDR: state_nxt = S_WRITE;
         S_WRITE: begin
            if (ack)               state_nxt = S_DONE;
            else if (wait_expired) state_nxt = S_ERR;
         end
         S_READ: begin
            if (ack)               state_nxt = S_DONE;
            else if (wait_expired) state_nxt = S_ERR;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs are registered: each is decoded from the state being
   // entered, so it is valid for the whole cycle that state is occupied.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         wr_flag  <= 1'b0;
         mar_en   <= 1'b0;
         mdr_ld_q <= 1'b0;
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         err_q    <= 1'b0;
         wait_cnt <= 8'd0;
`endif
      end else begin
         state    <= state_nxt;
         if ((state == S_IDLE) && req) wr_flag <= we;
         mar_en   <= (state_nxt == S_ADDR);
         mdr_ld_q <= (state_nxt == S_LDMDR);
         mem_rd   <= (state_nxt == S_READ);
         mem_wr   <= (state_nxt == S_WRITE);
         busy     <= (state_nxt != S_IDLE);
         done     <= (state_nxt == S_DONE);
`ifdef MEM_ACCESS_TIMEOUT_EN
         err_q    <= (state_nxt == S_ERR);
         // Held at zero outside the wait states, so it starts from zero on
         // every entry to READ/WRITE.
         if ((state != S_READ) && (state != S_WRITE))
            wait_cnt <= 8'd0;
         else if (!ack)
            wait_cnt <= wait_cnt + 8'd1;
`endif
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Every cycle is one vector: the inputs to hold during that cycle and the
// output word expected in that cycle, {mar_en, mdr_en, mdr_read, mem_rd,
// mem_wr, busy, done, err}. Inputs change 1 ns after the rising edge and the
// outputs are compared on the falling edge. Directed vectors come from a
// table. Random vectors are produced by a transaction model that expands
// each access (gap, direction, ack delay, optional reset abort) into its
// cycle-by-cycle output words.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

   localparam int TB_WAIT_MAX = 3;
`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // Expected output words per FSM phase.
   localparam logic [7:0] O_IDLE  = 8'b0000_0000;
   localparam logic [7:0] O_ADDR  = 8'b1000_0100;
   localparam logic [7:0] O_LDMDR = 8'b0100_0100;
   localparam logic [7:0] O_WR    = 8'b0000_1100;
   localparam logic [7:0] O_RD    = 8'b0001_0100;
   localparam logic [7:0] O_RDACK = 8'b0111_0100;
   localparam logic [7:0] O_DONE  = 8'b0000_0110;
   localparam logic [7:0] O_ERR   = 8'b0000_0101;

   typedef struct packed {
      logic       rst;
      logic       req;
      logic       we;
      logic       ack;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, req, we, ack;
   logic       mar_en, mdr_en, mdr_read, mem_rd, mem_wr, busy, done, err;
   logic [2:0] state_dbg;
   logic [7:0] dut_out;

   int n_vec = 0;
   int n_bad = 0;

   vec_t tbl[$];
   vec_t rq[$];

   mem_access_ctrl #(.WAIT_MAX(TB_WAIT_MAX)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .ack(ack),
      .mar_en(mar_en), .mdr_en(mdr_en), .mdr_read(mdr_read),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done),
      .err(err), .state_dbg(state_dbg)
   );

   assign dut_out = {mar_en, mdr_en, mdr_read, mem_rd, mem_wr, busy, done, err};

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic vec_t mk(logic r, logic q, logic w, logic a, logic [7:0] e);
      vec_t v;
      v.rst = r; v.req = q; v.we = w; v.ack = a; v.exp = e;
      return v;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic apply(input vec_t v, input string name);
      reset = v.rst; req = v.req; we = v.we; ack = v.ack;
      @(negedge clk);
      n_vec++;
      if (dut_out !== v.exp) begin
         n_bad++;
         $display("FAIL %s #%0d: outputs %b, expected %b (rst=%b req=%b we=%b ack=%b)",
                  name, n_vec, dut_out, v.exp, v.rst, v.req, v.we, v.ack);
      end
      @(posedge clk);
      #1;
   endtask

   // Reference model: expands one access into per-cycle vectors.
   //   gap   idle cycles with req=0 before the request
   //   wr    direction
   //   d     ack-low cycles before ack
   //   abort reset lands on a random busy cycle of this access
   task automatic gen_txn(input int gap, input logic wr, input int d, input bit abort);
      vec_t t[$];
      logic [7:0] strobe, strobe_ack;
      int k;
      for (int i = 0; i < gap; i++) rq.push_back(mk(0, 0, rb(), rb(), O_IDLE));
      strobe     = wr ? O_WR : O_RD;
      strobe_ack = wr ? O_WR : O_RDACK;
      t.push_back(mk(0, 1, wr, rb(), O_IDLE));
      t.push_back(mk(0, rb(), rb(), rb(), O_ADDR));
      if (wr) t.push_back(mk(0, rb(), rb(), rb(), O_LDMDR));
      if (TO_EN && d >= TB_WAIT_MAX) begin
         for (int i = 0; i < TB_WAIT_MAX; i++) t.push_back(mk(0, rb(), rb(), 0, strobe));
         t.push_back(mk(0, rb(), rb(), rb(), O_ERR));
      end else begin
         for (int i = 0; i < d; i++) t.push_back(mk(0, rb(), rb(), 0, strobe));
         t.push_back(mk(0, rb(), rb(), 1, strobe_ack));
         t.push_back(mk(0, rb(), rb(), rb(), O_DONE));
      end
      if (abort) begin
         k = $urandom_range(t.size() - 1, 1);
         t[k].rst = 1'b1;
         // Reset wins over ack: no MDR load in the aborted cycle.
         if (t[k].exp == O_RDACK) t[k].exp = O_RD;
         while (t.size() > k + 1) void'(t.pop_back());
      end
      foreach (t[i]) rq.push_back(t[i]);
   endtask

   // ---------------- stimulus and checking ----------------
   initial begin
      reset = 1'b1; req = 1'b0; we = 1'b0; ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state, reset priority over req/ack.
      tbl.push_back(mk(0, 0, 0, 0, O_IDLE));
      tbl.push_back(mk(1, 1, 1, 1, O_IDLE));
      tbl.push_back(mk(0, 0, 0, 0, O_IDLE));
      // Read, ack in first READ cycle: done in 3rd cycle after accept edge.
      tbl.push_back(mk(0, 1, 0, 0, O_IDLE));
      tbl.push_back(mk(0, 0, 1, 0, O_ADDR));
      tbl.push_back(mk(0, 0, 0, 1, O_RDACK));
      tbl.push_back(mk(0, 0, 0, 0, O_DONE));
      tbl.push_back(mk(0, 0, 0, 0, O_IDLE));
      // Write, ack after 4 low cycles: mem_wr 5 cycles, done in cycle 8.
      tbl.push_back(mk(0, 1, 1, 0, O_IDLE));
      tbl.push_back(mk(0, 1, 0, 1, O_ADDR));
      tbl.push_back(mk(0, 1, 0, 1, O_LDMDR));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 0, 0, O_WR));
      tbl.push_back(mk(0, 0, 0, 1, O_WR));
      tbl.push_back(mk(0, 0, 0, 0, O_DONE));
      tbl.push_back(mk(0, 0, 0, 0, O_IDLE));
      // Write with ack in first WRITE cycle.
      tbl.push_back(mk(0, 1, 1, 0, O_IDLE));
      tbl.push_back(mk(0, 0, 0, 0, O_ADDR));
      tbl.push_back(mk(0, 0, 0, 0, O_LDMDR));
      tbl.push_back(mk(0, 0, 0, 1, O_WR));
      tbl.push_back(mk(0, 0, 0, 0, O_DONE));
      // Reset in WRITE cycle 2, then a normal read.
      tbl.push_back(mk(0, 1, 1, 0, O_IDLE));
      tbl.push_back(mk(0, 0, 0, 0, O_ADDR));
      tbl.push_back(mk(0, 0, 0, 0, O_LDMDR));
      tbl.push_back(mk(0, 0, 0, 0, O_WR));
      tbl.push_back(mk(1, 0, 0, 1, O_WR));
      tbl.push_back(mk(0, 1, 0, 0, O_IDLE));
      tbl.push_back(mk(0, 0, 0, 0, O_ADDR));
      tbl.push_back(mk(0, 0, 0, 0, O_RD));
      tbl.push_back(mk(0, 0, 0, 1, O_RDACK));
      tbl.push_back(mk(0, 0, 0, 0, O_DONE));
      // Reset together with ack in READ: no MDR load, no done.
      tbl.push_back(mk(0, 1, 0, 0, O_IDLE));
      tbl.push_back(mk(0, 0, 0, 0, O_ADDR));
      tbl.push_back(mk(1, 0, 0, 1, O_RD));
      tbl.push_back(mk(0, 0, 0, 1, O_IDLE));
      // Stray ack in IDLE, then req held high: one access per IDLE visit.
      tbl.push_back(mk(0, 0, 0, 1, O_IDLE));
      tbl.push_back(mk(0, 1, 0, 1, O_IDLE));
      tbl.push_back(mk(0, 1, 1, 1, O_ADDR));
      tbl.push_back(mk(0, 1, 1, 1, O_RDACK));
      tbl.push_back(mk(0, 1, 1, 1, O_DONE));
      tbl.push_back(mk(0, 1, 1, 1, O_IDLE));
      tbl.push_back(mk(0, 1, 0, 1, O_ADDR));
      tbl.push_back(mk(0, 1, 0, 1, O_LDMDR));
      tbl.push_back(mk(0, 0, 0, 1, O_WR));
      tbl.push_back(mk(0, 0, 0, 1, O_DONE));
      tbl.push_back(mk(0, 0, 0, 1, O_IDLE));
      foreach (tbl[i]) apply(tbl[i], "table");

      // Long wait: timeout (macro on) or indefinite hold (macro off).
      apply(mk(0, 1, 0, 0, O_IDLE), "wait_req");
      apply(mk(0, 0, 0, 0, O_ADDR), "wait_addr");
      if (TO_EN) begin
         for (int i = 0; i < TB_WAIT_MAX; i++) apply(mk(0, 0, 0, 0, O_RD), "timeout_rd");
         apply(mk(0, 0, 0, 1, O_ERR), "timeout_err");
         apply(mk(0, 0, 0, 1, O_IDLE), "timeout_idle");
         // ack in the very last allowed cycle wins over the timeout.
         apply(mk(0, 1, 1, 0, O_IDLE), "lastack_req");
         apply(mk(0, 0, 0, 0, O_ADDR), "lastack_addr");
         apply(mk(0, 0, 0, 0, O_LDMDR), "lastack_ldmdr");
         for (int i = 0; i < TB_WAIT_MAX - 1; i++) apply(mk(0, 0, 0, 0, O_WR), "lastack_wr");
         apply(mk(0, 0, 0, 1, O_WR), "lastack_ack");
         apply(mk(0, 0, 0, 0, O_DONE), "lastack_done");
      end else begin
         for (int i = 0; i < 60; i++) apply(mk(0, 0, 0, 0, O_RD), "hold_rd");
         apply(mk(0, 0, 0, 1, O_RDACK), "hold_ack");
         apply(mk(0, 0, 0, 0, O_DONE), "hold_done");
      end
      apply(mk(0, 0, 0, 0, O_IDLE), "wait_end");

      // Randomized accesses against the transaction model.
      for (int n = 0; n < 250; n++)
         gen_txn($urandom_range(2, 0), rb(), $urandom_range(5, 0),
                 ($urandom_range(7, 0) == 0));
      rq.push_back(mk(0, 0, 0, 0, O_IDLE));
      while (rq.size() > 0) apply(rq.pop_front(), "random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum memory-wait cycles before timeout; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge, so enables are stable for the negedge-latching MAR/MDR registers.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req  input  1  access request from control unit; sampled only in IDLE.
REQ-005 we  input  1  1 = write access, 0 = read access; captured with req.
REQ-006 ack  input  1  memory ready/acknowledge.
REQ-007 mar_en  output  1  MAR load enable.
REQ-008 mdr_en  output  1  MDR load enable.
REQ-009 mdr_read  output  1  MDR input select: 1 = memory data, 0 = bus data.
REQ-010 mem_rd  output  1  memory read strobe.
REQ-011 mem_wr  output  1  memory write strobe.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle timeout pulse.

Function
REQ-015 States: IDLE, ADDR, LDMDR, WRITE, READ, DONE, ERR; all outputs are Moore decodes of state, except mdr_en and mdr_read in READ (REQ-020).
REQ-016 IDLE: all outputs 0; req=1 captures we into a flag and moves to ADDR; req=0 stays.
REQ-017 ADDR: mar_en=1 for exactly one cycle; next LDMDR if flag=1, else READ.
REQ-018 LDMDR: mdr_en=1, mdr_read=0 for one cycle; next WRITE.
REQ-019 WRITE: mem_wr=1 held until ack=1; on ack, next DONE.
REQ-020 READ: mem_rd=1 held; in the cycle ack=1, mdr_en=1 and mdr_read=1 combinationally, next DONE; mdr_en=0 while ack=0.
REQ-021 DONE: done=1 for one cycle; next IDLE unconditionally; new req accepted earliest in IDLE.
REQ-022 Minimum latency with ack in first wait cycle: read req edge -> done high 3 cycles later (ADDR, READ, DONE); write 4 cycles (ADDR, LDMDR, WRITE, DONE).
REQ-023 req while busy=1 is ignored, not queued; we changes after capture have no effect.
REQ-024 ack outside READ/WRITE is ignored.
REQ-025 mem_rd and mem_wr are never high simultaneously; mar_en and mdr_en never high simultaneously.
REQ-026 busy=1 and done=1 together only in DONE; err and done never together.

Reset
REQ-027 reset=1 on a rising edge forces IDLE, clears flag and wait counter; all outputs 0 on following cycle.
REQ-028 reset mid-access (any state) aborts with no done/err pulse and no further MDR load.
REQ-029 reset has priority over req and ack in the same cycle.

Configuration
REQ-030 Macro MEM_ACCESS_TIMEOUT_EN defined: an 8-bit wait counter clears on entry to READ/WRITE and increments each cycle ack=0; when it reaches WAIT_MAX with ack=0, next state ERR (err=1 one cycle, strobes 0, MDR not loaded), then IDLE.
REQ-031 ack=1 in the same cycle the counter reaches WAIT_MAX completes normally (ack wins).
REQ-032 Macro not defined: no counter, READ/WRITE wait indefinitely, err tied 0, state ERR unreachable.

Verification
REQ-033 Read: req=1,we=0; ack=1 in first READ cycle -> mar_en pulse, mem_rd 1 cycle with mdr_en=1,mdr_read=1, done 3 cycles after req edge.
REQ-034 Write with 4-cycle ack delay: req=1,we=1 -> mar_en, mdr_en with mdr_read=0, mem_wr high 5 cycles, done at cycle 8.
REQ-035 Timeout (macro on, WAIT_MAX=3): read, ack never -> mem_rd 3 cycles, err 1 cycle, mdr_en never 1, busy 0 after; macro off -> mem_rd held 50+ cycles, err stays 0.
REQ-036 Reset in WRITE cycle 2 -> next cycle all outputs 0, no done; following req=1,we=0 completes normally.
REQ-037 req held high through access plus stray ack in IDLE -> exactly one access per IDLE visit, stray ack causes no state change.
